pool_window_unit: RTL and testbench

//  2x2 pooling datapath fed by the pooling controller: takes one window of 4 feature-map addresses per beat,

---
 rtl/pool_window_if.sv | 25 ++
 rtl/pool_window_unit.sv | 216 +++++++++++++++++++++
 tb/tb_pool_window_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pool_window_if.sv
// Window-issue and result bus between the pooling controller and pool_window_unit.
// The master drives window beats and the slave returns pooled results.
interface pool_window_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic                   win_valid;
    logic [3:0][ADDR_W-1:0] win_addr;
    logic                   max_avg;
    logic                   win_last;
    logic                   res_valid;
    logic [DATA_W-1:0]      res_data;
    logic [3:0]             res_idx;
    logic                   done;

    modport master (
        output win_valid, win_addr, max_avg, win_last,
        input  res_valid, res_data, res_idx, done
    );

    modport slave (
        input  win_valid, win_addr, max_avg, win_last,
        output res_valid, res_data, res_idx, done
    );
endinterface

// File: rtl/pool_window_unit.sv
// 2x2 max/average pooling: map fetch, 3-stage reduce, output buffer indexed in issue order.
// Optional feature macro POOL_SIGNED_EN selects two's-complement operands.
module pool_window_unit #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int OUT_DEPTH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              clear,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    pool_window_if.slave      win
);
    localparam int                MAP_N    = 2 ** ADDR_W;
    localparam int                SUM_W    = DATA_W + 2;
    localparam logic [ADDR_W-1:0] PAD_ADDR = {ADDR_W{1'b1}};
    localparam logic [3:0]        DEPTH_C  = 4'(OUT_DEPTH);
    localparam logic [3:0]        LAST_IDX = 4'(OUT_DEPTH - 1);

    logic [DATA_W-1:0]      map_q     [MAP_N];
    logic [DATA_W-1:0]      map_d     [MAP_N];
    logic [DATA_W-1:0]      out_buf_q [OUT_DEPTH];
    logic [DATA_W-1:0]      out_buf_d [OUT_DEPTH];
    logic                   s1_valid_q, s1_valid_d, s1_max_q, s1_max_d, s1_last_q, s1_last_d;
    logic [3:0][ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [3:0]             s1_mask_q, s1_mask_d;
    logic                   s2_valid_q, s2_valid_d, s2_max_q, s2_max_d, s2_last_q, s2_last_d;
    logic [3:0][DATA_W-1:0] s2_op_q, s2_op_d;
    logic [3:0]             s2_mask_q, s2_mask_d;
    logic                   res_valid_q, res_valid_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0]      res_data_q, res_data_d, rd_data_q, rd_data_d;
    logic [3:0]             res_idx_q, res_idx_d, idx_q, idx_d;
    logic [DATA_W-1:0]      best_s, avg_s, result_s;
    logic [SUM_W-1:0]       sum_s;
    logic [2:0]             cnt_s;
    logic                   found_s, bad_cnt_s;

    function automatic logic [SUM_W-1:0] ext(input logic [DATA_W-1:0] v);
`ifdef POOL_SIGNED_EN
        return {{2{v[DATA_W-1]}}, v};
`else
        return {2'b00, v};
`endif
    endfunction

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef POOL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] shr(input logic [SUM_W-1:0] s, input logic [1:0] n);
        logic [SUM_W-1:0] t;
`ifdef POOL_SIGNED_EN
        t = SUM_W'($signed(s) >>> n);
`else
        t = s >> n;
`endif
        return t[DATA_W-1:0];
    endfunction

    // Map write port, window capture (S1) and map fetch (S2); the fetch sees pre-write contents.
    always_comb begin
        map_d = map_q;
        if (ld_en && (ld_addr != PAD_ADDR)) begin
            map_d[ld_addr] = ld_data;
        end else begin
            map_d = map_q;
        end
        s1_valid_d = win.win_valid;
        s1_addr_d  = win.win_addr;
        s1_max_d   = win.max_avg;
        s1_last_d  = win.win_last;
        for (int i = 0; i < 4; i++) begin
            s1_mask_d[i] = (win.win_addr[i] != PAD_ADDR);
            s2_op_d[i]   = s1_mask_q[i] ? map_q[s1_addr_q[i]] : {DATA_W{1'b0}};
        end
        s2_valid_d = s1_valid_q && !clear;
        s2_mask_d  = s1_mask_q;
        s2_max_d   = s1_max_q;
        s2_last_d  = s1_last_q;
    end

    // S3 reduction: max over unmasked lanes, or averaged sum scaled by lane count.
    always_comb begin
        best_s    = {DATA_W{1'b0}};
        found_s   = 1'b0;
        sum_s     = {SUM_W{1'b0}};
        cnt_s     = 3'd0;
        avg_s     = {DATA_W{1'b0}};
        bad_cnt_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s2_mask_q[i] && (!found_s || gt(s2_op_q[i], best_s))) begin
                best_s  = s2_op_q[i];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
            sum_s = sum_s + ext(s2_op_q[i]);
            cnt_s = cnt_s + {2'b00, s2_mask_q[i]};
        end
        case (cnt_s)
            3'd4:    avg_s = shr(sum_s, 2'd2);
            3'd2:    avg_s = shr(sum_s, 2'd1);
            3'd1:    avg_s = shr(sum_s, 2'd0);
            default: begin
                avg_s     = shr(sum_s, 2'd2);
                bad_cnt_s = !s2_max_q;
            end
        endcase
        result_s = s2_max_q ? best_s : avg_s;
    end

    // Result issue, output buffer write, index counter with saturation, sticky error, read port.
    always_comb begin
        res_valid_d = 1'b0;
        done_d      = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        idx_d       = idx_q;
        err_d       = err_q;
        out_buf_d   = out_buf_q;
        if (clear) begin
            idx_d = 4'd0;
            err_d = 1'b0;
        end else if (s2_valid_q) begin
            res_valid_d = 1'b1;
            res_data_d  = result_s;
            done_d      = s2_last_q;
            if (idx_q < DEPTH_C) begin
                res_idx_d = idx_q;
                idx_d     = idx_q + 4'd1;
                err_d     = err_q | bad_cnt_s;
                for (int j = 0; j < OUT_DEPTH; j++) begin
                    if (idx_q == 4'(j)) begin
                        out_buf_d[j] = result_s;
                    end else begin
                        out_buf_d[j] = out_buf_q[j];
                    end
                end
            end else begin
                res_idx_d = LAST_IDX;
                err_d     = 1'b1;
            end
        end else begin
            idx_d = idx_q;
        end
        rd_data_d = {DATA_W{1'b0}};
        for (int j = 0; j < OUT_DEPTH; j++) begin
            if (rd_addr == 4'(j)) begin
                rd_data_d = out_buf_q[j];
            end else begin
                rd_data_d = rd_data_d;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_q       <= '{default: {DATA_W{1'b0}}};
            out_buf_q   <= '{default: {DATA_W{1'b0}}};
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_mask_q   <= 4'd0;
            s1_max_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_op_q     <= '0;
            s2_mask_q   <= 4'd0;
            s2_max_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {DATA_W{1'b0}};
            res_idx_q   <= 4'd0;
            done_q      <= 1'b0;
            idx_q       <= 4'd0;
            err_q       <= 1'b0;
            rd_data_q   <= {DATA_W{1'b0}};
        end else begin
            map_q       <= map_d;
            out_buf_q   <= out_buf_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_mask_q   <= s1_mask_d;
            s1_max_q    <= s1_max_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_op_q     <= s2_op_d;
            s2_mask_q   <= s2_mask_d;
            s2_max_q    <= s2_max_d;
            s2_last_q   <= s2_last_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign err           = err_q;
    assign win.res_valid = res_valid_q;
    assign win.res_data  = res_data_q;
    assign win.res_idx   = res_idx_q;
    assign win.done      = done_q;
endmodule

// File: tb/tb_pool_window_unit.sv
// Scoreboard bench for pool_window_unit: directed windows push expected results,
// a negedge monitor pops and compares every presented result.
module tb_pool_window_unit;
    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic       clk, rst, ld_en, clear, err;
    logic [4:0] ld_addr;
    logic [7:0] ld_data, rd_data;
    logic [3:0] rd_addr;
    exp_t       sb[$];
    int         tests, failed, model_cnt;

    pool_window_if bus ();

    pool_window_unit dut (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .clear   (clear),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .err     (err),
        .win     (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endfunction

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_result: got data %0h idx %0d, required no result",
                         bus.res_data, bus.res_idx);
            end else begin
                e = sb.pop_front();
                check("res_data", 32'(bus.res_data), 32'(e.data));
                check("res_idx", 32'(bus.res_idx), 32'(e.idx));
                check("done", 32'(bus.done), 32'(e.last));
            end
        end else if (bus.done === 1'b1) begin
            check("done_without_valid", 32'(bus.done), 32'd0);
        end
    end

    task automatic load(input logic [4:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; model_cnt = 0;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] a3, input logic mx, input logic lst,
                         input logic [7:0] req, input logic push);
        exp_t e;
        bus.win_valid = 1'b1;
        bus.win_addr  = {a3, a2, a1, a0};
        bus.max_avg   = mx;
        bus.win_last  = lst;
        if (push) begin
            e.data = req;
            e.idx  = (model_cnt < 9) ? 4'(model_cnt) : 4'd8;
            e.last = lst;
            sb.push_back(e);
            if (model_cnt < 9) model_cnt++;
        end
        @(posedge clk); #1;
        bus.win_valid = 1'b0;
        bus.win_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout_pending", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input logic [3:0] a, input logic [7:0] req);
        rd_addr = a;
        @(posedge clk); #1;
        check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(req));
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; ld_en = 1'b0; ld_addr = 5'd0; ld_data = 8'd0;
        clear = 1'b0; rd_addr = 4'd0; tests = 0; failed = 0; model_cnt = 0;
        bus.win_valid = 1'b0; bus.win_addr = '0; bus.max_avg = 1'b0; bus.win_last = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        check("reset_res_valid", 32'(bus.res_valid), 32'd0);
        check("reset_res_data", 32'(bus.res_data), 32'd0);
        check("reset_res_idx", 32'(bus.res_idx), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);

        for (int i = 0; i < 25; i++) load(5'(i), 8'(i));
        do_clear();
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 8'd6, 1'b1);
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0, 8'd3, 1'b1);
        issue(5'd4, 5'd31, 5'd9, 5'd31, 1'b0, 1'b0, 8'd6, 1'b1);
        issue(5'd7, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 8'd7, 1'b1);
        issue(5'd31, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 8'd0, 1'b1);
        drain();
        check("err_after_legal_windows", 32'(err), 32'd0);
        issue(5'd10, 5'd11, 5'd12, 5'd31, 1'b0, 1'b0, 8'd8, 1'b1);
        drain();
        check("err_after_count3_avg", 32'(err), 32'd1);
        do_clear();
        check("err_after_clear", 32'(err), 32'd0);

        for (int i = 0; i < 9; i++)
            issue(5'(i), 5'(i), 5'(i), 5'(i), 1'b1, (i == 8), 8'(i), 1'b1);
        drain();
        check("err_after_9_windows", 32'(err), 32'd0);
        check_rd(4'd8, 8'd8);
        check_rd(4'd2, 8'd2);
        issue(5'd20, 5'd20, 5'd20, 5'd20, 1'b1, 1'b0, 8'd20, 1'b1);
        drain();
        check("err_after_overflow", 32'(err), 32'd1);
        check_rd(4'd8, 8'd8);
        check_rd(4'd9, 8'd0);
        check_rd(4'd15, 8'd0);

        do_clear();
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b1, 8'd6, 1'b0);
        do_clear();
        repeat (5) @(posedge clk);
        #1;
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b1, 8'd6, 1'b1);
        drain();
        clear = 1'b1; model_cnt = 0;
        issue(5'd4, 5'd31, 5'd9, 5'd31, 1'b0, 1'b0, 8'd6, 1'b1);
        clear = 1'b0;
        drain();

        do_clear();
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 8'd6, 1'b1);
        load(5'd6, 8'd99);
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 8'd99, 1'b1);
        drain();
        check_rd(4'd1, 8'd99);

`ifdef POOL_SIGNED_EN
        load(5'd0, 8'hFD); load(5'd1, 8'hFF); load(5'd5, 8'hF8); load(5'd6, 8'hFE);
        do_clear();
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 8'hFF, 1'b1);
        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0, 8'hFC, 1'b1);
        issue(5'd0, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 8'hFD, 1'b1);
        drain();
`endif

        issue(5'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b1, 8'd6, 1'b0);
        rst = 1'b1; model_cnt = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midop_reset_res_data", 32'(bus.res_data), 32'd0);
        check("midop_reset_err", 32'(err), 32'd0);
        check_rd(4'd0, 8'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
